// File: rtl/tx_conn_pkg.sv
// Shared types and ASCII constants for the DSKY serial-frame transmitter.
// Build option: TX_CONN_CHECKSUM_EN adds a checksum state to the enum.
package tx_conn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SOF,
    PROG,
    VERB,
    NOUN,
    R1,
    R2,
    R3,
`ifdef TX_CONN_CHECKSUM_EN
    CKSUM,
`endif
    EOF
  } state_t;

  localparam logic [7:0] CH_SOF  = 8'd60;
  localparam logic [7:0] CH_EOF  = 8'd62;
  localparam logic [7:0] CH_POS  = 8'd43;
  localparam logic [7:0] CH_NEG  = 8'd45;
  localparam logic [7:0] CH_ZERO = 8'd48;

  localparam int DIGITS_SHORT = 2;
  localparam int DIGITS_LONG  = 5;

  // Frozen copy of the display registers for the frame being sent.
  typedef struct packed {
    logic [1:0][2:0] prog;
    logic [1:0][2:0] verb;
    logic [1:0][2:0] noun;
    logic [4:0][2:0] r1;
    logic [4:0][2:0] r2;
    logic [4:0][2:0] r3;
    logic            sign_r1;
    logic            sign_r2;
    logic            sign_r3;
  } snap_t;

  function automatic logic [7:0] ascii_digit(input logic [2:0] d);
    return CH_ZERO + {5'd0, d};
  endfunction

  function automatic logic [7:0] ascii_sign(input logic s);
    return s ? CH_NEG : CH_POS;
  endfunction

endpackage

// File: rtl/tx_conn_byte_mux.sv
// Combinational byte selector: picks the snapshot digit/sign for the current
// state and byte counter and encodes it as ASCII (TX_CONN_CHECKSUM_EN adds CKSUM).
module tx_byte_mux
  import tx_conn_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_cnt,
  input  snap_t      i_snap,
`ifdef TX_CONN_CHECKSUM_EN
  input  logic [2:0] i_cksum,
`endif
  output logic [7:0] o_byte
);

  logic w_sign_slot;
  assign w_sign_slot = (i_cnt == 3'(DIGITS_LONG));

  always_comb begin
    o_byte = 8'd0;
    case (i_state)
      SOF:   o_byte = CH_SOF;
      PROG:  o_byte = ascii_digit(i_snap.prog[i_cnt[0]]);
      VERB:  o_byte = ascii_digit(i_snap.verb[i_cnt[0]]);
      NOUN:  o_byte = ascii_digit(i_snap.noun[i_cnt[0]]);
      // Counter value DIGITS_LONG is the trailing sign slot of a signed field
      R1:    o_byte = w_sign_slot ? ascii_sign(i_snap.sign_r1) : ascii_digit(i_snap.r1[i_cnt]);
      R2:    o_byte = w_sign_slot ? ascii_sign(i_snap.sign_r2) : ascii_digit(i_snap.r2[i_cnt]);
      R3:    o_byte = w_sign_slot ? ascii_sign(i_snap.sign_r3) : ascii_digit(i_snap.r3[i_cnt]);
`ifdef TX_CONN_CHECKSUM_EN
      CKSUM: o_byte = ascii_digit(i_cksum);
`endif
      EOF:   o_byte = CH_EOF;
      default: o_byte = 8'd0;
    endcase
  end

endmodule

// File: rtl/tx_conn.sv
// DSKY link transmitter: snapshots the display registers on start and streams
// one ASCII frame over valid/ready. Build option: TX_CONN_CHECKSUM_EN.
module tx_conn
  import tx_conn_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0][2:0] data_PROG,
  input  logic [1:0][2:0] data_VERB,
  input  logic [1:0][2:0] data_NOUN,
  input  logic [4:0][2:0] data_R1,
  input  logic [4:0][2:0] data_R2,
  input  logic [4:0][2:0] data_R3,
  input  logic            sign_R1,
  input  logic            sign_R2,
  input  logic            sign_R3,
  input  logic            TX_ready,
  output logic [7:0]      TX_byte,
  output logic            TX_valid,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

  state_t     r_state, r_state_next;
  logic [2:0] r_cnt, r_cnt_next;
  logic [3:0] r_gap, r_gap_next;
  logic       r_pending, r_pending_next;
  logic       r_valid, r_valid_next;
  logic       r_done, r_done_next;
  snap_t      r_snap, r_snap_next;
  snap_t      w_snap_in;
  state_t     w_field_next;
  logic       w_last;
  logic       w_xfer;
  logic [7:0] w_tx_byte;
`ifdef TX_CONN_CHECKSUM_EN
  logic [2:0] r_cksum, r_cksum_next;
  logic       w_digit;
`endif

  always_comb begin
    w_snap_in         = '0;
    w_snap_in.prog    = data_PROG;
    w_snap_in.verb    = data_VERB;
    w_snap_in.noun    = data_NOUN;
    w_snap_in.r1      = data_R1;
    w_snap_in.r2      = data_R2;
    w_snap_in.r3      = data_R3;
    w_snap_in.sign_r1 = sign_R1;
    w_snap_in.sign_r2 = sign_R2;
    w_snap_in.sign_r3 = sign_R3;
  end

  tx_byte_mux u_mux (
    .i_state (r_state),
    .i_cnt   (r_cnt),
    .i_snap  (r_snap),
`ifdef TX_CONN_CHECKSUM_EN
    .i_cksum (r_cksum),
`endif
    .o_byte  (w_tx_byte)
  );

  assign w_xfer = r_valid & TX_ready;

  always_comb begin
    w_last       = 1'b1;
    w_field_next = IDLE;
    case (r_state)
      SOF:  w_field_next = PROG;
      PROG: begin w_field_next = VERB; w_last = (r_cnt == 3'(DIGITS_SHORT - 1)); end
      VERB: begin w_field_next = NOUN; w_last = (r_cnt == 3'(DIGITS_SHORT - 1)); end
      NOUN: begin w_field_next = R1;   w_last = (r_cnt == 3'(DIGITS_SHORT - 1)); end
      R1:   begin w_field_next = R2;   w_last = (r_cnt == 3'(DIGITS_LONG)); end
      R2:   begin w_field_next = R3;   w_last = (r_cnt == 3'(DIGITS_LONG)); end
`ifdef TX_CONN_CHECKSUM_EN
      R3:    begin w_field_next = CKSUM; w_last = (r_cnt == 3'(DIGITS_LONG)); end
      CKSUM: w_field_next = EOF;
`else
      R3:   begin w_field_next = EOF;  w_last = (r_cnt == 3'(DIGITS_LONG)); end
`endif
      default: w_field_next = IDLE;
    endcase
  end

`ifdef TX_CONN_CHECKSUM_EN
  // Only magnitude digits feed the checksum; signs and delimiters do not
  always_comb begin
    w_digit = 1'b0;
    case (r_state)
      PROG, VERB, NOUN: w_digit = 1'b1;
      R1, R2, R3:       w_digit = (r_cnt != 3'(DIGITS_LONG));
      default:          w_digit = 1'b0;
    endcase
  end
`endif

  always_comb begin
    r_state_next   = r_state;
    r_cnt_next     = r_cnt;
    r_gap_next     = r_gap;
    r_pending_next = r_pending;
    r_snap_next    = r_snap;
    r_valid_next   = r_valid;
    r_done_next    = 1'b0;
`ifdef TX_CONN_CHECKSUM_EN
    r_cksum_next   = r_cksum;
`endif
    if (r_state == IDLE) begin
      if (start) begin
        r_snap_next  = w_snap_in;
        r_state_next = SOF;
        r_cnt_next   = '0;
        r_gap_next   = '0;
        r_valid_next = 1'b1;
`ifdef TX_CONN_CHECKSUM_EN
        r_cksum_next = '0;
`endif
      end
    end else begin
      if (start) r_pending_next = 1'b1;
      if (w_xfer) begin
`ifdef TX_CONN_CHECKSUM_EN
        if (w_digit) r_cksum_next = r_cksum ^ w_tx_byte[2:0];
`endif
        if (w_last) begin
          r_cnt_next   = '0;
          r_state_next = w_field_next;
        end else begin
          r_cnt_next = r_cnt + 3'd1;
        end
        if (GAP_CYCLES == 0) begin
          r_valid_next = 1'b1;
        end else begin
          r_valid_next = 1'b0;
          r_gap_next   = GAP_LD;
        end
        if (r_state == EOF) begin
          r_done_next = 1'b1;
          // A request arriving with the final byte still counts as pending
          if (r_pending || start) begin
            r_snap_next    = w_snap_in;
            r_pending_next = 1'b0;
            r_state_next   = SOF;
`ifdef TX_CONN_CHECKSUM_EN
            r_cksum_next   = '0;
`endif
          end else begin
            r_state_next = IDLE;
            r_valid_next = 1'b0;
            r_gap_next   = '0;
          end
        end
      end else if (!r_valid && r_gap != 4'd0) begin
        r_gap_next = r_gap - 4'd1;
        if (r_gap == 4'd1) r_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_pending <= 1'b0;
      r_snap    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
`ifdef TX_CONN_CHECKSUM_EN
      r_cksum   <= '0;
`endif
    end else begin
      r_state   <= r_state_next;
      r_cnt     <= r_cnt_next;
      r_gap     <= r_gap_next;
      r_pending <= r_pending_next;
      r_snap    <= r_snap_next;
      r_valid   <= r_valid_next;
      r_done    <= r_done_next;
`ifdef TX_CONN_CHECKSUM_EN
      r_cksum   <= r_cksum_next;
`endif
    end
  end

  assign TX_byte    = w_tx_byte;
  assign TX_valid   = r_valid;
  assign busy       = (r_state != IDLE) | r_pending;
  assign frame_done = r_done;

endmodule
